// File: rtl/uart_rx_fifo.sv
// UART receive-side FIFO: synchronises the receiver's data_ready, captures byte+parity into a
// circular buffer with a 4-phase acknowledge. Optional macro UART_RX_FIFO_THRESHOLD_IRQ_EN adds thresh.
module uart_rx_fifo #(
   parameter int DEPTH_LOG2  = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [7:0]            rx_data,
   input  logic                  rx_parity_ok,
   input  logic                  rx_ready,
   output logic                  rx_ack,
   input  logic                  rd_en,
   output logic [7:0]            rd_data,
   output logic                  rd_parity_err,
   output logic                  empty,
   output logic                  full,
   output logic [DEPTH_LOG2:0]   count,
   output logic                  overrun,
   input  logic                  clr_overrun,
`ifdef UART_RX_FIFO_THRESHOLD_IRQ_EN
   input  logic [DEPTH_LOG2:0]   thresh,
`endif
   output logic                  irq
);

   localparam int                DEPTH    = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

   typedef enum logic [1:0] {IDLE, CAPTURE, ACK} state_t;

   state_t                  state;
   logic [SYNC_STAGES-1:0]  sync_q;
   logic                    rdy_s;
   logic [8:0]              mem [DEPTH];
   logic [DEPTH_LOG2-1:0]   wr_ptr;
   logic [DEPTH_LOG2-1:0]   rd_ptr;
   logic                    do_wr;
   logic                    do_rd;

   // NOTE: sequential state always uses non-blocking assignments so every flop sees pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) sync_q <= '0;
      else        sync_q <= {sync_q[SYNC_STAGES-2:0], rx_ready};
   end

   assign rdy_s = sync_q[SYNC_STAGES-1];

   // A pop while full frees the slot the pending capture needs, so full alone does not block it.
   assign do_rd = rd_en && !empty;
   assign do_wr = (state == CAPTURE) && (!full || rd_en);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         rx_ack  <= 1'b0;
         overrun <= 1'b0;
      end else begin
         if (state == CAPTURE && !do_wr) overrun <= 1'b1;
         else if (clr_overrun)           overrun <= 1'b0;

         case (state)
            IDLE:    if (rdy_s) state <= CAPTURE;
            CAPTURE: begin
               state  <= ACK;
               rx_ack <= 1'b1;
            end
            ACK:     if (!rdy_s) begin
               state  <= IDLE;
               rx_ack <= 1'b0;
            end
            default: begin
               state  <= IDLE;
               rx_ack <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + 1'b1;
         if (do_rd) rd_ptr <= rd_ptr + 1'b1;
         case ({do_wr, do_rd})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // NOTE: storage has no reset so it maps onto plain RAM; only the pointers define validity.
   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr] <= {~rx_parity_ok, rx_data};
   end

   assign {rd_parity_err, rd_data} = mem[rd_ptr];

   assign empty = (count == '0);
   assign full  = (count == FULL_CNT);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         irq <= 1'b0;
      end else begin
`ifdef UART_RX_FIFO_THRESHOLD_IRQ_EN
         irq <= ((count >= thresh) && (thresh != '0)) || overrun;
`else
         irq <= !empty;
`endif
      end
   end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: stimulus pushes expected entries, a negedge monitor
// compares the head entry on every accepted pop.
`timescale 1ns/1ps
module tb_uart_rx_fifo;

   localparam int DEPTH_LOG2  = 4;
   localparam int SYNC_STAGES = 2;

   logic                clk = 1'b0;
   logic                reset = 1'b0;
   logic [7:0]          rx_data = '0;
   logic                rx_parity_ok = 1'b1;
   logic                rx_ready = 1'b0;
   logic                rx_ack;
   logic                rd_en = 1'b0;
   logic [7:0]          rd_data;
   logic                rd_parity_err;
   logic                empty;
   logic                full;
   logic [DEPTH_LOG2:0] count;
   logic                overrun;
   logic                clr_overrun = 1'b0;
   logic                irq;
`ifdef UART_RX_FIFO_THRESHOLD_IRQ_EN
   logic [DEPTH_LOG2:0] thresh = 5'd4;
`endif

   int         n_vec = 0;
   int         n_err = 0;
   logic [8:0] exp_q[$];

   uart_rx_fifo #(.DEPTH_LOG2(DEPTH_LOG2), .SYNC_STAGES(SYNC_STAGES)) dut (
      .clk           (clk),
      .reset         (reset),
      .rx_data       (rx_data),
      .rx_parity_ok  (rx_parity_ok),
      .rx_ready      (rx_ready),
      .rx_ack        (rx_ack),
      .rd_en         (rd_en),
      .rd_data       (rd_data),
      .rd_parity_err (rd_parity_err),
      .empty         (empty),
      .full          (full),
      .count         (count),
      .overrun       (overrun),
      .clr_overrun   (clr_overrun),
`ifdef UART_RX_FIFO_THRESHOLD_IRQ_EN
      .thresh        (thresh),
`endif
      .irq           (irq)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ack(input logic lvl, input string name);
      int n = 0;
      while (rx_ack !== lvl && n < 40) begin
         tick();
         n++;
      end
      check(name, 32'(rx_ack), 32'(lvl));
   endtask

   task automatic send_byte(input logic [7:0] d, input logic pok, input logic accept);
      rx_data      = d;
      rx_parity_ok = pok;
      rx_ready     = 1'b1;
      if (accept) exp_q.push_back({~pok, d});
      wait_ack(1'b1, "ack_rise");
      rx_ready = 1'b0;
      wait_ack(1'b0, "ack_fall");
   endtask

   task automatic pop1();
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
   endtask

   // Scoreboard monitor: every pop the DUT will accept at the next edge is compared here.
   initial begin
      logic [8:0] e;
      forever begin
         @(negedge clk);
         if (reset && rd_en && !empty) begin
            if (exp_q.size() == 0) begin
               check("sb_unexpected_pop", 32'({rd_parity_err, rd_data}), 32'h1ff);
            end else begin
               e = exp_q.pop_front();
               check("sb_rd", 32'({rd_parity_err, rd_data}), 32'(e));
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      #2;
      check("rst_empty", 32'(empty), 1);
      check("rst_count", 32'(count), 0);
      repeat (2) tick();
      reset = 1'b1;
      tick();
      check("rst_full", 32'(full), 0);
      check("rst_overrun", 32'(overrun), 0);
      check("rst_ack", 32'(rx_ack), 0);
      check("rst_irq", 32'(irq), 0);

      // Single byte with latency: rise in cycle 0, CAPTURE in cycle SYNC_STAGES+1
      rx_data = 8'hA5; rx_parity_ok = 1'b1; rx_ready = 1'b1;
      exp_q.push_back(9'h0A5);
      repeat (SYNC_STAGES + 1) tick();
      check("lat_cnt_pre", 32'(count), 0);
      check("lat_ack_pre", 32'(rx_ack), 0);
      tick();
      check("lat_cnt", 32'(count), 1);
      check("lat_ack", 32'(rx_ack), 1);
      check("irq_lag", 32'(irq), 0);
      rx_ready = 1'b0;
      repeat (SYNC_STAGES) tick();
      check("ack_hold", 32'(rx_ack), 1);
      tick();
      check("ack_drop_lat", 32'(rx_ack), 0);
`ifdef UART_RX_FIFO_THRESHOLD_IRQ_EN
      check("irq_one", 32'(irq), 0);
`else
      check("irq_one", 32'(irq), 1);
`endif
      check("one_empty", 32'(empty), 0);
      check("one_rd_data", 32'(rd_data), 'hA5);
      check("one_perr", 32'(rd_parity_err), 0);
      pop1();
      check("one_popped_empty", 32'(empty), 1);

      // Parity error flag, then a good byte
      send_byte(8'h3C, 1'b0, 1'b1);
      check("perr_head", 32'(rd_parity_err), 1);
      check("perr_data", 32'(rd_data), 'h3C);
      pop1();
      send_byte(8'h01, 1'b1, 1'b1);
      check("pok_head", 32'(rd_parity_err), 0);
      pop1();

      // Fill to full, then overrun
      for (int i = 0; i < 16; i++) send_byte(8'(i), 1'b1, 1'b1);
      check("fill_full", 32'(full), 1);
      check("fill_count", 32'(count), 16);
      send_byte(8'hFF, 1'b1, 1'b0);
      check("ovr_set", 32'(overrun), 1);
      check("ovr_count", 32'(count), 16);
      check("ovr_irq", 32'(irq), 1);
      for (int i = 0; i < 16; i++) pop1();
      check("ovr_drained", 32'(empty), 1);
      check("ovr_sticky", 32'(overrun), 1);
      clr_overrun = 1'b1;
      tick();
      clr_overrun = 1'b0;
      check("ovr_clr", 32'(overrun), 0);

      // Pop during the CAPTURE cycle of a byte arriving while full
      for (int i = 0; i < 16; i++) send_byte(8'(8'h10 + i), 1'b1, 1'b1);
      rx_data = 8'h77; rx_parity_ok = 1'b1; rx_ready = 1'b1;
      exp_q.push_back(9'h077);
      repeat (SYNC_STAGES + 1) tick();
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      check("pp_count", 32'(count), 16);
      check("pp_full", 32'(full), 1);
      check("pp_no_ovr", 32'(overrun), 0);
      check("pp_ack", 32'(rx_ack), 1);
      rx_ready = 1'b0;
      wait_ack(1'b0, "pp_ack_fall");
      for (int i = 0; i < 16; i++) pop1();
      check("pp_drained", 32'(count), 0);

      // Interleaved traffic across pointer wrap
      for (int i = 0; i < 40; i++) begin
         send_byte(8'(i * 5 + 2), (i % 3) != 0, 1'b1);
         if (i % 2 == 1) begin
            pop1();
            pop1();
         end
      end
      check("wrap_empty", 32'(empty), 1);

      // Pop while empty is ignored
      rd_en = 1'b1;
      repeat (3) tick();
      rd_en = 1'b0;
      check("uf_count", 32'(count), 0);
      check("uf_empty", 32'(empty), 1);
      send_byte(8'hC3, 1'b1, 1'b1);
      check("uf_next_data", 32'(rd_data), 'hC3);
      pop1();

      // Reset during ACK with rx_ready still high
      rx_data = 8'h5A; rx_parity_ok = 1'b1; rx_ready = 1'b1;
      wait_ack(1'b1, "rst_pre_ack");
      reset = 1'b0;
      #2;
      check("rst_mid_ack", 32'(rx_ack), 0);
      check("rst_mid_count", 32'(count), 0);
      tick();
      reset = 1'b1;
      exp_q.push_back(9'h05A);
      wait_ack(1'b1, "rst_recap_ack");
      check("rst_recap_count", 32'(count), 1);
      rx_ready = 1'b0;
      wait_ack(1'b0, "rst_recap_fall");
      check("rst_once", 32'(count), 1);
      for (int n = 2; n <= 4; n++) begin
         send_byte(8'(8'h60 + n), 1'b1, 1'b1);
`ifdef UART_RX_FIFO_THRESHOLD_IRQ_EN
         check("thr_irq", 32'(irq), (n >= 4) ? 1 : 0);
`else
         check("thr_irq", 32'(irq), 1);
`endif
      end
      for (int i = 0; i < 4; i++) pop1();

      repeat (3) tick();
      check("sb_drained", 32'(exp_q.size()), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
